// File: rtl/pipe_mux_reg.sv
// rtl/pipe_mux_reg.sv - N:1 selector with a stall/flush-capable pipeline register
module pipe_mux_reg #(
   parameter int          WIDTH     = 32,
   parameter int          NUM_IN    = 4,
   parameter int          SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
   parameter logic [31:0] RESET_VAL = 32'h0000_0013
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_bus,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   input  logic                    stall,
   input  logic                    flush,
   output logic [WIDTH-1:0]        y,
   output logic                    out_valid,
   output logic                    sel_err
);

   // Bubble value: the NOP encoding, truncated or zero-extended to the data width.
   localparam logic [WIDTH-1:0] BUBBLE_Y = WIDTH'(RESET_VAL);

   // Input count expressed one bit wider than sel so the range compare cannot wrap.
   localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

   logic [WIDTH-1:0] mux_y;
   logic             sel_bad;

   // An out-of-range select only exists when NUM_IN is not a power of two.
   assign sel_bad = ({1'b0, sel} >= NUM_IN_L);

   // Pick input[sel]; anything out of range falls back to input 0.
   always_comb begin
      mux_y = in_bus[WIDTH-1:0];
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            mux_y = in_bus[k*WIDTH +: WIDTH];
         end
      end
   end

   // Stage register: reset > flush > stall > load; sel_err is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         y         <= BUBBLE_Y;
         out_valid <= 1'b0;
         sel_err   <= 1'b0;
      end else if (flush) begin
         y         <= BUBBLE_Y;
         out_valid <= 1'b0;
      end else if (!stall) begin
         y         <= mux_y;
         out_valid <= in_valid;
         if (in_valid && sel_bad) begin
            sel_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_mux_reg.sv
// tb/tb_pipe_mux_reg.sv - self-checking bench for pipe_mux_reg (NUM_IN=4 and NUM_IN=3)
module tb_pipe_mux_reg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          stall;
   logic          in_valid;
   logic [1:0]    sel;
   logic [31:0]   w [4];
   logic [127:0]  in_bus4;
   logic [95:0]   in_bus3;
   logic [31:0]   y4, y3;
   logic          v4, v3, e4, e3;

   int checks;
   int failures;

   assign in_bus4 = {w[3], w[2], w[1], w[0]};
   assign in_bus3 = {w[2], w[1], w[0]};

   pipe_mux_reg #(.WIDTH(32), .NUM_IN(4)) u4 (
      .clk(clk), .rst(rst), .in_bus(in_bus4), .sel(sel), .in_valid(in_valid),
      .stall(stall), .flush(flush), .y(y4), .out_valid(v4), .sel_err(e4)
   );

   pipe_mux_reg #(.WIDTH(32), .NUM_IN(3)) u3 (
      .clk(clk), .rst(rst), .in_bus(in_bus3), .sel(sel), .in_valid(in_valid),
      .stall(stall), .flush(flush), .y(y3), .out_valid(v3), .sel_err(e3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, flush, stall, iv, chg;
      logic [1:0]  sel;
      logic [31:0] y4;
      logic        v4, e4;
      logic [31:0] y3;
      logic        v3, e3;
   } vec_t;

   vec_t tbl [20];

   // Behavioural reference state, one slot per configuration (0: NUM_IN=4, 1: NUM_IN=3).
   logic [31:0] m_y   [2];
   logic        m_v   [2];
   logic        m_err [2];

   function automatic vec_t mk(input logic r, input logic f, input logic s, input logic iv,
                               input logic chg, input logic [1:0] sl,
                               input logic [31:0] ya, input logic va, input logic ea,
                               input logic [31:0] yb, input logic vb, input logic eb);
      vec_t t;
      t.rst = r; t.flush = f; t.stall = s; t.iv = iv; t.chg = chg; t.sel = sl;
      t.y4 = ya; t.v4 = va; t.e4 = ea; t.y3 = yb; t.v3 = vb; t.e3 = eb;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic std_words();
      w[0] = 32'h1111_1111; w[1] = 32'h2222_2222;
      w[2] = 32'h3333_3333; w[3] = 32'h4444_4444;
   endtask

   task automatic rnd_words();
      for (int k = 0; k < 4; k++) w[k] = $urandom;
   endtask

   // Expected next state from the operation rules, for a block with n inputs.
   task automatic model_edge(input int c, input int n);
      int idx;
      if (rst) begin
         m_y[c] = NOP; m_v[c] = 1'b0; m_err[c] = 1'b0;
      end else if (flush) begin
         m_y[c] = NOP; m_v[c] = 1'b0;
      end else if (!stall) begin
         idx = (int'(sel) < n) ? int'(sel) : 0;
         m_y[c] = w[idx];
         m_v[c] = in_valid;
         if (in_valid && int'(sel) >= n) m_err[c] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(0, 4);
      model_edge(1, 3);
      #1;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; sel = 2'd0;
      std_words();

      //               rst flu stl iv chg sel  y4            v4 e4  y3            v3 e3
      tbl[0]  = mk(1, 0, 0, 1, 1, 2'd2, NOP,          0, 0, NOP,          0, 0);
      tbl[1]  = mk(1, 0, 0, 1, 1, 2'd2, NOP,          0, 0, NOP,          0, 0);
      tbl[2]  = mk(0, 0, 0, 1, 0, 2'd0, 32'h11111111, 1, 0, 32'h11111111, 1, 0);
      tbl[3]  = mk(0, 0, 0, 1, 0, 2'd1, 32'h22222222, 1, 0, 32'h22222222, 1, 0);
      tbl[4]  = mk(0, 0, 0, 1, 0, 2'd2, 32'h33333333, 1, 0, 32'h33333333, 1, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 2'd3, 32'h44444444, 0, 0, 32'h11111111, 0, 0);
      tbl[6]  = mk(0, 0, 0, 1, 0, 2'd3, 32'h44444444, 1, 0, 32'h11111111, 1, 1);
      tbl[7]  = mk(0, 0, 0, 1, 0, 2'd1, 32'h22222222, 1, 0, 32'h22222222, 1, 1);
      tbl[8]  = mk(0, 0, 1, 1, 1, 2'd3, 32'h22222222, 1, 0, 32'h22222222, 1, 1);
      tbl[9]  = mk(0, 0, 1, 0, 1, 2'd0, 32'h22222222, 1, 0, 32'h22222222, 1, 1);
      tbl[10] = mk(0, 0, 1, 1, 1, 2'd2, 32'h22222222, 1, 0, 32'h22222222, 1, 1);
      tbl[11] = mk(0, 0, 0, 1, 0, 2'd3, 32'h44444444, 1, 0, 32'h11111111, 1, 1);
      tbl[12] = mk(0, 1, 1, 1, 1, 2'd1, NOP,          0, 0, NOP,          0, 1);
      tbl[13] = mk(0, 0, 0, 1, 0, 2'd2, 32'h33333333, 1, 0, 32'h33333333, 1, 1);
      tbl[14] = mk(0, 0, 0, 0, 0, 2'd2, 32'h33333333, 0, 0, 32'h33333333, 0, 1);
      tbl[15] = mk(0, 0, 0, 1, 0, 2'd0, 32'h11111111, 1, 0, 32'h11111111, 1, 1);
      tbl[16] = mk(0, 1, 0, 1, 1, 2'd0, NOP,          0, 0, NOP,          0, 1);
      tbl[17] = mk(0, 0, 0, 1, 0, 2'd1, 32'h22222222, 1, 0, 32'h22222222, 1, 1);
      tbl[18] = mk(1, 1, 1, 1, 1, 2'd3, NOP,          0, 0, NOP,          0, 0);
      tbl[19] = mk(0, 0, 0, 0, 0, 2'd3, 32'h44444444, 0, 0, 32'h11111111, 0, 0);

      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         rst = tbl[i].rst; flush = tbl[i].flush; stall = tbl[i].stall;
         in_valid = tbl[i].iv; sel = tbl[i].sel;
         if (tbl[i].chg) rnd_words(); else std_words();
         tick();
         check($sformatf("row%0d y4", i), y4, tbl[i].y4);
         check($sformatf("row%0d valid4", i), 32'(v4), 32'(tbl[i].v4));
         check($sformatf("row%0d sel_err4", i), 32'(e4), 32'(tbl[i].e4));
         check($sformatf("row%0d y3", i), y3, tbl[i].y3);
         check($sformatf("row%0d valid3", i), 32'(v3), 32'(tbl[i].v3));
         check($sformatf("row%0d sel_err3", i), 32'(e3), 32'(tbl[i].e3));
      end

      // Randomized run against the reference model; the first cycle resets to align it.
      for (int i = 0; i < 400; i++) begin
         rst      = (i == 0) || ($urandom_range(0, 19) == 0);
         flush    = ($urandom_range(0, 7) == 0);
         stall    = ($urandom_range(0, 3) == 0);
         in_valid = $urandom_range(0, 1);
         sel      = 2'($urandom_range(0, 3));
         rnd_words();
         tick();
         check($sformatf("rnd%0d y4", i), y4, m_y[0]);
         check($sformatf("rnd%0d valid4", i), 32'(v4), 32'(m_v[0]));
         check($sformatf("rnd%0d sel_err4", i), 32'(e4), 32'(m_err[0]));
         check($sformatf("rnd%0d y3", i), y3, m_y[1]);
         check($sformatf("rnd%0d valid3", i), 32'(v3), 32'(m_v[1]));
         check($sformatf("rnd%0d sel_err3", i), 32'(e3), 32'(m_err[1]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
